rs_latch_ctrl: RTL and testbench
================================

Name: rs_latch_ctrl

Overview:
- Clocked controller that sequences a NOR-style RS storage cell for the lab board.
- Debounces the S and R panel switches.
- Offers an auto-demo mode that steps the cell through set/hold/reset/hold on a slow tick.
- Flags the forbidden S=R=1 input and drives Q, Qn and status LEDs.
- Sits between the board switches/LEDs and the top level; replaces the raw combinational latch in the lab top.

Parameters:
- DB_CYCLES, 16, clk cycles a switch must be stable before its debounced value updates (>=2).
- TICK_DIV, 1000, clk cycles per demo tick (>=2).
- STEP_TICKS, 4, demo ticks spent in each auto-demo phase (>=1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sw1_S  input  1  raw set switch, asynchronous to clk
- sw2_R  input  1  raw reset switch, asynchronous to clk
- sw3_auto  input  1  raw mode switch: 1 = auto demo, 0 = manual
- led8_Q  output  1  Q
- led7_Qn  output  1  Qn
- led6_err  output  1  forbidden input currently applied
- led5_auto  output  1  auto mode active
- led_phase  output  2  FSM phase: 0 HOLD, 1 SET, 2 RESET, 3 FORBID

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - led8_Q=0, led7_Qn=1, led6_err=0, led5_auto=0, led_phase=0.
  - Debouncers cleared to 0; tick prescaler and step counter cleared; demo phase = SET-pending.
- Input synchronisation: each raw switch passes a 2-FF synchroniser, then a debouncer.
- Debouncer:
  - Debounced output changes only after the synchronised input differs from it for DB_CYCLES consecutive clocks.
  - Any bounce restarts the count.
- Source selection:
  - Manual (debounced auto=0): effective S/R = debounced sw1/sw2.
  - Auto (debounced auto=1): effective S/R come from the demo sequencer.
  - Effective S/R are registered one cycle before the cell update.
  - Cell latency is 2 clk from a debounced change to the LED change.
- Cell update (each clk, from effective S,R):
  - 00: HOLD, Q/Qn unchanged, phase 0.
  - 10: SET, Q=1, Qn=0, phase 1.
  - 01: RESET, Q=0, Qn=1, phase 2.
  - 11: FORBID, Q=0, Qn=0, err=1, phase 3 (models NOR outputs).
  - err=0 in all other states.
  - FORBID→00 resolves deterministically to Q=0, Qn=1; no oscillation is modelled.
  - FORBID→10 or 01 follows the normal row.
- Demo sequencer:
  - Prescaler counts 0..TICK_DIV-1 and emits a 1-clk tick at wrap.
  - Step counter wraps at STEP_TICKS-1.
  - Phase order SET→HOLD→RESET→HOLD→SET…; advances on the tick where the step counter wraps.
  - The sequencer never produces 11.
- Mode switching:
  - Entering auto clears the prescaler and step counter and starts at SET.
  - The cell state is not cleared on a mode change.
  - Leaving auto returns to manual S/R the next cycle; Q is held if manual S/R = 00.
  - In auto mode the physical S/R switches are ignored (and cannot raise err).
- led5_auto = registered debounced auto.
- Reset asserted mid-sequence: all state returns to reset values immediately; release is glitch-free.

Optional Feature:
- Macro: RS_LATCH_CTRL_EVCNT_EN.
- When defined:
  - Adds output led_cnt [7:0], reset 0.
  - Increments on each clk where Q rises 0→1 (any mode); wraps 255→0.
  - Saturates nothing; err cycles are not counted.
- When undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package rs_pkg:
  - Phase encoding constants PH_HOLD=2'd0, PH_SET=2'd1, PH_RESET=2'd2, PH_FORBID=2'd3.
  - Demo-sequence order constants.
- One sub-module: sw_debounce (2-FF sync + stability counter, parameter DB_CYCLES), instantiated three times.
- Prescaler, sequencer and cell stay in rs_latch_ctrl.

Test Plan (DB_CYCLES=4, TICK_DIV=4, STEP_TICKS=2):
- Reset and set/reset:
  - Stimulus: hold rst_n=0 mid-activity; release.
  - Response: Q=0, Qn=1, err=0, phase=0 while reset is held.
  - Stimulus: sw1_S=1 stable.
  - Response: Q=1, Qn=0, phase=1 exactly 2+4+2 clk after the edge.
  - Stimulus: release S, then set sw2_R=1.
  - Response: Q returns to 0, Qn to 1.
- Bounce: toggle sw1_S 1/0 every 2 clk for 20 clk, then settle at 0 → Q never changes, phase stays 0.
- Forbidden:
  - Stimulus: S=1, R=1.
  - Response: Q=0, Qn=0, err=1, phase=3.
  - Stimulus: both released.
  - Response: Q=0, Qn=1, err=0.
  - Stimulus: S=1, R=1 again, then R released.
  - Response: Q=1.
- Auto demo:
  - Stimulus: sw3_auto=1.
  - Response: phases SET, HOLD, RESET, HOLD, each lasting 8 clk; Q=1 during the first HOLD, Q=0 during the second.
  - Stimulus: S/R toggled during auto.
  - Response: no effect, err stays 0.
- Mode exit: auto off during SET phase with manual S/R=00 → Q stays 1, phase=0, led5_auto=0.
- With RS_LATCH_CTRL_EVCNT_EN defined:
  - Stimulus: 3 manual set/reset cycles.
  - Response: led_cnt=3.
  - Stimulus: a FORBID→00 sequence.
  - Response: led_cnt does not increment.
  - Stimulus: 256 Q rises.
  - Response: led_cnt wraps to 0.

Source files
------------

// File: rtl/rs_latch_ctrl_pkg.sv
// Shared types for the RS storage-cell controller: cell phase encoding and
// auto-demo sequence order.
package rs_pkg;

    typedef enum logic [1:0] {
        PH_HOLD   = 2'd0,
        PH_SET    = 2'd1,
        PH_RESET  = 2'd2,
        PH_FORBID = 2'd3
    } ph_e;

    typedef enum logic [1:0] {
        DM_SET    = 2'd0,
        DM_HOLD_A = 2'd1,
        DM_RESET  = 2'd2,
        DM_HOLD_B = 2'd3
    } demo_e;

    localparam demo_e DEMO_FIRST = DM_SET;

    function automatic demo_e demo_next(input demo_e d);
        demo_e n;
        case (d)
            DM_SET:    n = DM_HOLD_A;
            DM_HOLD_A: n = DM_RESET;
            DM_RESET:  n = DM_HOLD_B;
            default:   n = DM_SET;
        endcase
        return n;
    endfunction

    // {S,R} presented to the cell for each demo step; never 2'b11.
    function automatic logic [1:0] demo_sr(input demo_e d);
        logic [1:0] sr;
        case (d)
            DM_SET:   sr = 2'b10;
            DM_RESET: sr = 2'b01;
            default:  sr = 2'b00;
        endcase
        return sr;
    endfunction

endpackage

// File: rtl/rs_latch_ctrl_if.sv
// Board-side switch/LED bundle for rs_latch_ctrl. The LED event counter
// signal exists only when RS_LATCH_CTRL_EVCNT_EN is defined.
interface rs_latch_ctrl_if;
    logic       sw1_S;
    logic       sw2_R;
    logic       sw3_auto;
    logic       led8_Q;
    logic       led7_Qn;
    logic       led6_err;
    logic       led5_auto;
    logic [1:0] led_phase;
`ifdef RS_LATCH_CTRL_EVCNT_EN
    logic [7:0] led_cnt;

    modport master (
        output sw1_S, sw2_R, sw3_auto,
        input  led8_Q, led7_Qn, led6_err, led5_auto, led_phase, led_cnt
    );
    modport slave (
        input  sw1_S, sw2_R, sw3_auto,
        output led8_Q, led7_Qn, led6_err, led5_auto, led_phase, led_cnt
    );
`else
    modport master (
        output sw1_S, sw2_R, sw3_auto,
        input  led8_Q, led7_Qn, led6_err, led5_auto, led_phase
    );
    modport slave (
        input  sw1_S, sw2_R, sw3_auto,
        output led8_Q, led7_Qn, led6_err, led5_auto, led_phase
    );
`endif
endinterface

// File: rtl/rs_latch_ctrl_sw_debounce.sv
// Two-flop synchroniser followed by a stability debouncer: the output follows
// the synchronised input once it has differed for DB_CYCLES consecutive clocks.
module sw_debounce #(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db
);
    localparam int unsigned CW = $clog2(DB_CYCLES);

    logic          s1_q;
    logic          s2_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            cnt_q <= '0;
            db    <= 1'b0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
            if (s2_q != db) begin
                if (cnt_q == CW'(DB_CYCLES - 1)) begin
                    db    <= s2_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end
endmodule

// File: rtl/rs_latch_ctrl.sv
// Clocked NOR-style RS cell controller: debounced manual S/R or auto demo
// sequence. Optional Q-rise counter on led_cnt via RS_LATCH_CTRL_EVCNT_EN.
module rs_latch_ctrl
    import rs_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = 16,
    parameter int unsigned TICK_DIV   = 1000,
    parameter int unsigned STEP_TICKS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    rs_latch_ctrl_if.slave bus
);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

    logic db_s, db_r, db_auto;

    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_s (
        .clk(clk), .rst_n(rst_n), .raw(bus.sw1_S), .db(db_s)
    );
    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_r (
        .clk(clk), .rst_n(rst_n), .raw(bus.sw2_R), .db(db_r)
    );
    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_auto (
        .clk(clk), .rst_n(rst_n), .raw(bus.sw3_auto), .db(db_auto)
    );

    logic [PW-1:0] pre_q;
    logic [SW-1:0] step_q;
    logic          tick;
    logic          step_wrap;
    demo_e         demo_q, demo_d;

    assign tick      = (pre_q == PW'(TICK_DIV - 1));
    assign step_wrap = tick && (step_q == SW'(STEP_TICKS - 1));

    // Sequencer is held at its start point while in manual mode, so entering
    // auto always begins a fresh SET step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            step_q <= '0;
        end else if (!db_auto) begin
            pre_q  <= '0;
            step_q <= '0;
        end else begin
            pre_q <= tick ? '0 : pre_q + PW'(1);
            if (tick) begin
                step_q <= step_wrap ? '0 : step_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) demo_q <= DEMO_FIRST;
        else        demo_q <= demo_d;
    end

    always_comb begin
        demo_d = demo_q;
        if (!db_auto)       demo_d = DEMO_FIRST;
        else if (step_wrap) demo_d = demo_next(demo_q);
    end

    logic [1:0] eff_q;
    logic       auto_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eff_q  <= '0;
            auto_q <= 1'b0;
        end else begin
            eff_q  <= db_auto ? demo_sr(demo_q) : {db_s, db_r};
            auto_q <= db_auto;
        end
    end

    ph_e  ph_q, ph_d;
    logic q_q, q_d;
    logic qn_q, qn_d;
    logic err_q, err_d;

    // HOLD regenerates Qn from Q, which also resolves the FORBID (0,0) pair
    // deterministically to Q=0, Qn=1.
    always_comb begin
        q_d   = q_q;
        qn_d  = ~q_q;
        err_d = 1'b0;
        ph_d  = PH_HOLD;
        case (eff_q)
            2'b10: begin
                q_d  = 1'b1;
                qn_d = 1'b0;
                ph_d = PH_SET;
            end
            2'b01: begin
                q_d  = 1'b0;
                qn_d = 1'b1;
                ph_d = PH_RESET;
            end
            2'b11: begin
                q_d   = 1'b0;
                qn_d  = 1'b0;
                err_d = 1'b1;
                ph_d  = PH_FORBID;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= 1'b0;
            qn_q  <= 1'b1;
            err_q <= 1'b0;
            ph_q  <= PH_HOLD;
        end else begin
            q_q   <= q_d;
            qn_q  <= qn_d;
            err_q <= err_d;
            ph_q  <= ph_d;
        end
    end

    assign bus.led8_Q    = q_q;
    assign bus.led7_Qn   = qn_q;
    assign bus.led6_err  = err_q;
    assign bus.led5_auto = auto_q;
    assign bus.led_phase = ph_q;

`ifdef RS_LATCH_CTRL_EVCNT_EN
    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             cnt_q <= '0;
        else if (q_d && !q_q)   cnt_q <= cnt_q + 8'd1;
    end

    assign bus.led_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rs_latch_ctrl.sv
// Self-checking bench for rs_latch_ctrl: directed steps plus random switch
// activity, compared every cycle against a behavioural model.
module tb_rs_latch_ctrl;
    localparam int unsigned DB  = 4;
    localparam int unsigned TD  = 4;
    localparam int unsigned ST  = 2;
    localparam int unsigned PHL = TD * ST;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rs_latch_ctrl_if bus ();

    rs_latch_ctrl #(.DB_CYCLES(DB), .TICK_DIV(TD), .STEP_TICKS(ST)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned n_fail = 0;

    // Model: raw sample history, debounced values with run lengths, cycles
    // since auto became active, effective S/R, and cell outputs.
    bit          m_hist [3][2];
    bit          m_db   [3];
    int unsigned m_run  [3];
    int unsigned m_j;
    bit [1:0]    m_eff;
    bit          m_q, m_qn, m_err, m_auto;
    int unsigned m_ph;
    int unsigned m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit [1:0] demo_model(input int unsigned j);
        int unsigned seg = (j / PHL) % 4;
        if (seg == 0) return 2'b10;
        if (seg == 2) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_hist[k][0] = 0; m_hist[k][1] = 0; m_db[k] = 0; m_run[k] = 0;
        end
        m_j = 0; m_eff = 2'b00; m_q = 0; m_qn = 1; m_err = 0; m_auto = 0;
        m_ph = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        bit          raw_now [3];
        bit          seen    [3];
        bit          o_db    [3];
        bit [1:0]    o_eff;
        int unsigned o_j;
        bit          nq, nqn;
        raw_now[0] = bus.sw1_S; raw_now[1] = bus.sw2_R; raw_now[2] = bus.sw3_auto;
        for (int k = 0; k < 3; k++) begin
            seen[k] = m_hist[k][1];
            o_db[k] = m_db[k];
        end
        o_eff = m_eff;
        o_j   = m_j;
        case (o_eff)
            2'b10:   begin nq = 1; nqn = 0; m_err = 0; m_ph = 1; end
            2'b01:   begin nq = 0; nqn = 1; m_err = 0; m_ph = 2; end
            2'b11:   begin nq = 0; nqn = 0; m_err = 1; m_ph = 3; end
            default: begin
                m_err = 0; m_ph = 0;
                if (!m_q && !m_qn) begin nq = 0; nqn = 1; end
                else begin nq = m_q; nqn = m_qn; end
            end
        endcase
        if (nq && !m_q) m_cnt = (m_cnt + 1) % 256;
        m_q = nq; m_qn = nqn;
        m_auto = o_db[2];
        m_eff  = o_db[2] ? demo_model(o_j) : {o_db[0], o_db[1]};
        for (int k = 0; k < 3; k++) begin
            if (seen[k] != m_db[k]) begin
                m_run[k]++;
                if (m_run[k] == DB) begin m_db[k] = seen[k]; m_run[k] = 0; end
            end else begin
                m_run[k] = 0;
            end
            m_hist[k][1] = m_hist[k][0];
            m_hist[k][0] = raw_now[k];
        end
        m_j = (m_db[2] && o_db[2]) ? o_j + 1 : 0;
    endtask

    task automatic check_all();
        check("q",     32'(bus.led8_Q),    32'(m_q));
        check("qn",    32'(bus.led7_Qn),   32'(m_qn));
        check("err",   32'(bus.led6_err),  32'(m_err));
        check("auto",  32'(bus.led5_auto), 32'(m_auto));
        check("phase", 32'(bus.led_phase), m_ph);
`ifdef RS_LATCH_CTRL_EVCNT_EN
        check("cnt",   32'(bus.led_cnt),   m_cnt);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        @(negedge clk);
        check_all();
    endtask

    task automatic ticks(input int unsigned n);
        repeat (n) tick();
    endtask

    task automatic set_sw(input bit s, input bit r, input bit a);
        bus.sw1_S = s; bus.sw2_R = r; bus.sw3_auto = a;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_async_q",   32'(bus.led8_Q),    32'd0);
        check("rst_async_qn",  32'(bus.led7_Qn),   32'd1);
        check("rst_async_err", 32'(bus.led6_err),  32'd0);
        check("rst_async_ph",  32'(bus.led_phase), 32'd0);
        ticks(3);
        rst_n = 1'b1;
    endtask

    initial begin
        int unsigned k;
        bit          found;
        bit          s, r;

        set_sw(0, 0, 0);
        model_reset();
        @(negedge clk);
        ticks(3);
        check("rst_q",    32'(bus.led8_Q),    32'd0);
        check("rst_qn",   32'(bus.led7_Qn),   32'd1);
        check("rst_auto", 32'(bus.led5_auto), 32'd0);
        rst_n = 1'b1;
        ticks(2);

        // Set latency: 2 sync + DB debounce + 2 cell pipeline.
        set_sw(1, 0, 0);
        ticks(2 + DB + 1);
        check("lat_pre_q", 32'(bus.led8_Q), 32'd0);
        tick();
        check("lat_q",  32'(bus.led8_Q),    32'd1);
        check("lat_qn", 32'(bus.led7_Qn),   32'd0);
        check("lat_ph", 32'(bus.led_phase), 32'd1);
        set_sw(0, 0, 0); ticks(10);
        set_sw(0, 1, 0); ticks(10);
        check("reset_q",  32'(bus.led8_Q),    32'd0);
        check("reset_qn", 32'(bus.led7_Qn),   32'd1);
        check("reset_ph", 32'(bus.led_phase), 32'd2);
        set_sw(0, 0, 0); ticks(10);

        // Reset asserted mid-activity.
        set_sw(1, 0, 0); ticks(5);
        pulse_reset();
        ticks(12);
        check("post_rst_q", 32'(bus.led8_Q), 32'd1);
        set_sw(0, 1, 0); ticks(12);
        set_sw(0, 0, 0); ticks(8);

        // Bounce shorter than the debounce window.
        for (int i = 0; i < 10; i++) begin
            set_sw(1'(i % 2 == 0), 0, 0);
            ticks(2);
        end
        set_sw(0, 0, 0); ticks(10);
        check("bounce_q",  32'(bus.led8_Q),    32'd0);
        check("bounce_ph", 32'(bus.led_phase), 32'd0);

        // Forbidden input and its resolution.
        set_sw(1, 1, 0); ticks(10);
        check("forbid_q",   32'(bus.led8_Q),    32'd0);
        check("forbid_qn",  32'(bus.led7_Qn),   32'd0);
        check("forbid_err", 32'(bus.led6_err),  32'd1);
        check("forbid_ph",  32'(bus.led_phase), 32'd3);
        set_sw(0, 0, 0); ticks(10);
        check("resolve_q",   32'(bus.led8_Q),   32'd0);
        check("resolve_qn",  32'(bus.led7_Qn),  32'd1);
        check("resolve_err", 32'(bus.led6_err), 32'd0);
        set_sw(1, 1, 0); ticks(10);
        set_sw(1, 0, 0); ticks(10);
        check("forbid_set_q", 32'(bus.led8_Q), 32'd1);
        set_sw(0, 0, 0); ticks(10);
        set_sw(0, 1, 0); ticks(10);
        set_sw(0, 0, 0); ticks(8);

        // Random manual activity, including short bounces.
        for (int i = 0; i < 40; i++) begin
            set_sw(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            ticks($urandom_range(1, 12));
        end
        set_sw(0, 0, 0); ticks(12);
        set_sw(0, 1, 0); ticks(10);
        set_sw(0, 0, 0); ticks(8);

        // Auto demo: wait for first SET, then follow four phases.
        set_sw(0, 0, 1);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (bus.led_phase == 2'd1) found = 1;
        end
        check("auto_start_seen", 32'(found), 32'd1);
        check("auto_led", 32'(bus.led5_auto), 32'd1);
        for (k = 1; k < 4 * PHL; k++) begin
            s = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            set_sw(s, r, 1);
            tick();
            check("auto_seq_ph", 32'(bus.led_phase),
                  ((k / PHL) == 0) ? 32'd1 : ((k / PHL) == 2) ? 32'd2 : 32'd0);
            check("auto_seq_q", 32'(bus.led8_Q), (k < 2 * PHL) ? 32'd1 : 32'd0);
            check("auto_err",   32'(bus.led6_err), 32'd0);
        end

        // Leave auto during a SET phase with manual S/R idle.
        set_sw(0, 0, 1);
        found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            tick();
            if (bus.led_phase == 2'd1) found = 1;
        end
        check("exit_set_seen", 32'(found), 32'd1);
        set_sw(0, 0, 0);
        ticks(12);
        check("exit_q",    32'(bus.led8_Q),    32'd1);
        check("exit_ph",   32'(bus.led_phase), 32'd0);
        check("exit_auto", 32'(bus.led5_auto), 32'd0);

        // Random mixed activity across both modes.
        for (int i = 0; i < 30; i++) begin
            set_sw(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 2) == 0));
            ticks($urandom_range(1, 40));
        end
        set_sw(0, 0, 0); ticks(20);

`ifdef RS_LATCH_CTRL_EVCNT_EN
        pulse_reset();
        ticks(2);
        for (int i = 0; i < 3; i++) begin
            set_sw(1, 0, 0); ticks(8);
            set_sw(0, 1, 0); ticks(8);
        end
        set_sw(0, 0, 0); ticks(8);
        check("cnt_three", 32'(bus.led_cnt), 32'd3);
        set_sw(1, 1, 0); ticks(10);
        set_sw(0, 0, 0); ticks(10);
        check("cnt_forbid", 32'(bus.led_cnt), 32'd3);
        for (int i = 0; i < 253; i++) begin
            set_sw(1, 0, 0); ticks(8);
            set_sw(0, 1, 0); ticks(8);
        end
        set_sw(0, 0, 0); ticks(8);
        check("cnt_wrap", 32'(bus.led_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
